maquina_estados_mascota: RTL and testbench
==========================================

Name: maquina_estados_mascota

Overview:
- Consumer side of the mode/button block's interface: reads the four 2-bit need levels and the 5-second action pulses, and decides the pet's state.
- Returns the `Activo_Comida` / `Activo_Medicina` enables that gate the Energía and Medicina modes.
- Drives a 3-bit state code for the display and a death flag.
- Sits between the mode/button block and the display/LED drivers.

Parameters:
- EVAL_NORMAL, 50_000_000: clk cycles between state evaluations in normal mode.
- EVAL_TEST, 5_000_000: clk cycles between evaluations in test mode.
- HOLD_CYCLES, 100_000_000: clk cycles spent in ATENDIDO after a successful care action.
- MUERTE_EVALS, 12: consecutive evaluations with any level at 0 before death (range 1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- Reset_General  input  1  debounced user reset; synchronous, active-high, level.
- Bot_Test_pulse  input  1  debounced one-cycle pulse; toggles test mode.
- Nivel_Animo  input  2  mood level, 0 = empty, 3 = full.
- Nivel_Energia  input  2  energy level.
- Nivel_Descanso  input  2  rest level.
- Nivel_Medicina  input  2  health level.
- senal_5segEnergia  input  1  one-cycle pulse: feed action completed.
- senal_5segMedicina  input  1  one-cycle pulse: medicine action completed.
- Activo_Comida  output  1  enable for the Energía mode.
- Activo_Medicina  output  1  enable for the Medicina mode.
- estado  output  3  current state code.
- muerto  output  1  high in MUERTO.
- modo_test  output  1  test-mode indicator.

Behaviour:
- Async reset (reset=0):
  - State: estado=NEUTRAL (0).
  - Counters: prescaler=0, hold=0, cnt_muerte=0.
  - Outputs: modo_test=0, muerto=0, Activo_Comida=1, Activo_Medicina=1.
- State codes: NEUTRAL=0, FELIZ=1, TRISTE=2, HAMBRIENTO=3, ENFERMO=4, DORMIDO=5, ATENDIDO=6, MUERTO=7.
- Prescaler:
  - Counts 0..P-1, with P = EVAL_TEST when modo_test=1, else EVAL_NORMAL.
  - eval is an internal one-cycle strobe when prescaler = P-1; the prescaler then wraps to 0.
- Bot_Test_pulse:
  - Toggles modo_test and clears the prescaler.
  - If it coincides with eval, the eval is suppressed.
- Death counter, updated on eval when state is not ATENDIDO/MUERTO:
  - If any level = 0, cnt_muerte increments (saturating at 255); otherwise it clears to 0.
  - When the incremented value reaches MUERTE_EVALS, next state = MUERTO, overriding all other rules.
- Eval next-state priority, outside DORMIDO/ATENDIDO/MUERTO:
  1. Medicina=0 → ENFERMO.
  2. Energia=0 → HAMBRIENTO.
  3. Descanso=0 → DORMIDO.
  4. Animo=0 → TRISTE.
  5. All four levels = 3 → FELIZ.
  6. Otherwise → NEUTRAL.
- DORMIDO:
  - On eval, leave only if Medicina=0 (→ ENFERMO) or Descanso ≥ 2 (→ apply the priority list).
  - Otherwise stay (hysteresis).
- ATENDIDO:
  - Entered on the cycle after senal_5segEnergia while in HAMBRIENTO, or senal_5segMedicina while in ENFERMO.
  - Either qualifying pulse suffices if both arrive together.
  - Hold counter loads 0 and counts each clk; at HOLD_CYCLES-1 the next state is NEUTRAL.
  - No eval transitions in ATENDIDO; the death counter is frozen.
  - Further senal pulses are ignored.
- Non-qualifying senal pulses (wrong state) are ignored.
- MUERTO is absorbing: only reset=0 or Reset_General=1 exits.
- Reset_General=1 (sampled each clk):
  - Same effect as async reset, except modo_test is preserved.
  - Has priority over eval, senal pulses, and test toggle.
- Outputs are registered and change on the same edge as estado:
  - Activo_Comida = 0 in DORMIDO, ENFERMO, ATENDIDO, MUERTO; 1 otherwise.
  - Activo_Medicina = 0 in DORMIDO, ATENDIDO, MUERTO; 1 otherwise.
  - muerto = (estado == MUERTO).
- Latency: state change visible 1 clk after the eval strobe or qualifying pulse.

Test Plan (bench params: EVAL_NORMAL=20, EVAL_TEST=4, HOLD_CYCLES=6, MUERTE_EVALS=3):
- Reset release with all levels = 3 → estado=0 until the first eval (cycle 20), then estado=1; Activo_Comida=1, Activo_Medicina=1.
- Energia=0, others = 2 → estado=3 at the first eval. senal_5segEnergia pulse → estado=6 next cycle with Activo_Comida=0; after 6 cycles estado=0.
- Medicina=0 and Energia=0 simultaneously → estado=4 (ENFERMO has priority); Activo_Comida=0, Activo_Medicina=1.
- Descanso=0 → estado=5. Raise Descanso to 1 → still 5 at the next eval. Raise to 2 → leaves DORMIDO at the next eval.
- Animo held at 0 for 3 evals → estado=7, muerto=1. Restoring levels keeps 7. Reset_General=1 → estado=0, muerto=0 next cycle.
- Bot_Test_pulse → modo_test=1 and evals every 4 cycles. Test pulse coincident with eval → no state change, prescaler restarts. Async reset mid-ATENDIDO → estado=0, modo_test=0 immediately.

Source files
------------

// File: rtl/maquina_estados_mascota.sv
// Pet state machine.
//
// Consumes the four 2-bit need levels and the 5-second action pulses from the mode/button block.
// At each evaluation strobe it decides the pet's state.
//
// It returns the enables that gate the Energia and Medicina modes. It also drives the state code
// for the display and the death flag.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-low reset
//   Reset_General       synchronous active-high user reset (keeps modo_test)
//   Bot_Test_pulse      one-cycle pulse, toggles test mode
//   Nivel_Animo         mood level (0 empty .. 3 full)
//   Nivel_Energia       energy level
//   Nivel_Descanso      rest level
//   Nivel_Medicina      health level
//   senal_5segEnergia   one-cycle pulse, feed action completed
//   senal_5segMedicina  one-cycle pulse, medicine action completed
//   Activo_Comida       enable for the Energia mode
//   Activo_Medicina     enable for the Medicina mode
//   estado              state code (NEUTRAL=0 .. MUERTO=7)
//   muerto              high while dead
//   modo_test           test-mode indicator
module maquina_estados_mascota #(
  parameter int unsigned EVAL_NORMAL  = 50_000_000,
  parameter int unsigned EVAL_TEST    = 5_000_000,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned MUERTE_EVALS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Reset_General,
  input  logic       Bot_Test_pulse,
  input  logic [1:0] Nivel_Animo,
  input  logic [1:0] Nivel_Energia,
  input  logic [1:0] Nivel_Descanso,
  input  logic [1:0] Nivel_Medicina,
  input  logic       senal_5segEnergia,
  input  logic       senal_5segMedicina,
  output logic       Activo_Comida,
  output logic       Activo_Medicina,
  output logic [2:0] estado,
  output logic       muerto,
  output logic       modo_test
);

  typedef enum logic [2:0] {
    StNeutral    = 3'd0,
    StFeliz      = 3'd1,
    StTriste     = 3'd2,
    StHambriento = 3'd3,
    StEnfermo    = 3'd4,
    StDormido    = 3'd5,
    StAtendido   = 3'd6,
    StMuerto     = 3'd7
  } estado_e;

  localparam logic [7:0]  MuerteLim = 8'(MUERTE_EVALS);
  localparam logic [31:0] HoldLast  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] EvalNLast = 32'(EVAL_NORMAL - 1);
  localparam logic [31:0] EvalTLast = 32'(EVAL_TEST - 1);

  estado_e     state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        modo_q, modo_d;
  logic        act_c_q, act_c_d;
  logic        act_m_q, act_m_d;
  logic        muerto_q, muerto_d;

  logic [31:0] presc_last;
  logic        presc_wrap;
  logic        eval;
  logic        any_zero;
  logic        all_full;
  logic [7:0]  cnt_inc;
  logic        care_ok;
  estado_e     prio_st;

  assign presc_last = modo_q ? EvalTLast : EvalNLast;
  assign presc_wrap = (presc_q == presc_last);
  // A test-mode toggle on the same cycle swallows the strobe.
  assign eval       = presc_wrap && !Bot_Test_pulse;

  assign any_zero = (Nivel_Animo == 2'd0) || (Nivel_Energia == 2'd0) ||
                    (Nivel_Descanso == 2'd0) || (Nivel_Medicina == 2'd0);
  assign all_full = (Nivel_Animo == 2'd3) && (Nivel_Energia == 2'd3) &&
                    (Nivel_Descanso == 2'd3) && (Nivel_Medicina == 2'd3);
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  assign care_ok = ((state_q == StHambriento) && senal_5segEnergia) ||
                   ((state_q == StEnfermo) && senal_5segMedicina);

  // Need priority: health, then hunger, then sleep, then mood.
  always_comb begin
    prio_st = StNeutral;
    if (Nivel_Medicina == 2'd0)      prio_st = StEnfermo;
    else if (Nivel_Energia == 2'd0)  prio_st = StHambriento;
    else if (Nivel_Descanso == 2'd0) prio_st = StDormido;
    else if (Nivel_Animo == 2'd0)    prio_st = StTriste;
    else if (all_full)               prio_st = StFeliz;
    else                             prio_st = StNeutral;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_wrap ? 32'd0 : presc_q + 32'd1;
    hold_d  = (state_q == StAtendido) ? hold_q + 32'd1 : 32'd0;
    cnt_d   = cnt_q;
    modo_d  = modo_q;

    if (Reset_General) begin
      state_d = StNeutral;
      presc_d = 32'd0;
      hold_d  = 32'd0;
      cnt_d   = 8'd0;
    end else begin
      if (Bot_Test_pulse) begin
        modo_d  = ~modo_q;
        presc_d = 32'd0;
      end
      unique case (state_q)
        StMuerto: state_d = StMuerto;
        StAtendido: begin
          if (hold_q == HoldLast) state_d = StNeutral;
        end
        default: begin
          if (eval) begin
            cnt_d = any_zero ? cnt_inc : 8'd0;
            // Sleep hysteresis: wake only when rested enough or sick.
            if (state_q != StDormido ||
                Nivel_Medicina == 2'd0 || Nivel_Descanso >= 2'd2) begin
              state_d = prio_st;
            end
          end
          if (care_ok) begin
            state_d = StAtendido;
            hold_d  = 32'd0;
          end
          if (eval && any_zero && (cnt_inc == MuerteLim)) state_d = StMuerto;
        end
      endcase
    end

    act_c_d  = !((state_d == StDormido) || (state_d == StEnfermo) ||
                 (state_d == StAtendido) || (state_d == StMuerto));
    act_m_d  = !((state_d == StDormido) || (state_d == StAtendido) ||
                 (state_d == StMuerto));
    muerto_d = (state_d == StMuerto);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StNeutral;
      presc_q  <= 32'd0;
      hold_q   <= 32'd0;
      cnt_q    <= 8'd0;
      modo_q   <= 1'b0;
      act_c_q  <= 1'b1;
      act_m_q  <= 1'b1;
      muerto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      modo_q   <= modo_d;
      act_c_q  <= act_c_d;
      act_m_q  <= act_m_d;
      muerto_q <= muerto_d;
    end
  end

  assign estado          = state_q;
  assign Activo_Comida   = act_c_q;
  assign Activo_Medicina = act_m_q;
  assign muerto          = muerto_q;
  assign modo_test       = modo_q;

endmodule

// File: tb/tb_maquina_estados_mascota.sv
module tb_maquina_estados_mascota;

  logic       clk = 1'b0;
  logic       reset;
  logic       Reset_General;
  logic       Bot_Test_pulse;
  logic [1:0] Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina;
  logic       senal_5segEnergia, senal_5segMedicina;
  logic       Activo_Comida, Activo_Medicina, muerto, modo_test;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maquina_estados_mascota #(
    .EVAL_NORMAL (20),
    .EVAL_TEST   (4),
    .HOLD_CYCLES (6),
    .MUERTE_EVALS(3)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Reset_General     (Reset_General),
    .Bot_Test_pulse    (Bot_Test_pulse),
    .Nivel_Animo       (Nivel_Animo),
    .Nivel_Energia     (Nivel_Energia),
    .Nivel_Descanso    (Nivel_Descanso),
    .Nivel_Medicina    (Nivel_Medicina),
    .senal_5segEnergia (senal_5segEnergia),
    .senal_5segMedicina(senal_5segMedicina),
    .Activo_Comida     (Activo_Comida),
    .Activo_Medicina   (Activo_Medicina),
    .estado            (estado),
    .muerto            (muerto),
    .modo_test         (modo_test)
  );

  // Levels and one-shot controls held for 'ticks' clocks; controls are pulsed on the first clock.
  typedef struct {
    logic [1:0]  a, e, d, m;
    logic        rg, tst, pe, pm;
    int unsigned ticks;
    logic [2:0]  est;
    logic        ac, am, mu, mt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic [1:0] a, e, d, m, input logic rg, tst, pe, pm,
                              input int unsigned ticks, input logic [2:0] est,
                              input logic ac, am, mu, mt);
    vec_t v;
    v.a = a; v.e = e; v.d = d; v.m = m;
    v.rg = rg; v.tst = tst; v.pe = pe; v.pm = pm;
    v.ticks = ticks; v.est = est;
    v.ac = ac; v.am = am; v.mu = mu; v.mt = mt;
    return v;
  endfunction

  task automatic set_levels(input logic [1:0] a, e, d, m);
    Nivel_Animo = a; Nivel_Energia = e; Nivel_Descanso = d; Nivel_Medicina = m;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
      @(negedge clk);
      Reset_General = 1'b0; Bot_Test_pulse = 1'b0;
      senal_5segEnergia = 1'b0; senal_5segMedicina = 1'b0;
    end
  endtask

  // Packed as {estado, Activo_Comida, Activo_Medicina, muerto, modo_test}.
  task automatic check(input string name, input logic [2:0] est, input logic ac, am, mu, mt);
    logic [6:0] got, exp;
    got = {estado, Activo_Comida, Activo_Medicina, muerto, modo_test};
    exp = {est, ac, am, mu, mt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {estado,AC,AM,muerto,test}=%b_%b%b%b%b expected %b_%b%b%b%b",
               name, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    set_levels(v.a, v.e, v.d, v.m);
    Reset_General = v.rg; Bot_Test_pulse = v.tst;
    senal_5segEnergia = v.pe; senal_5segMedicina = v.pm;
    tick(v.ticks);
  endtask

  initial begin
    //          A  E  D  M  rg tst pe pm  ticks est AC AM mu mt
    tbl[0]  = mk(3, 3, 3, 3, 0, 0, 0, 0, 19, 0, 1, 1, 0, 0); // before first eval
    tbl[1]  = mk(3, 3, 3, 3, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0); // FELIZ at cycle 20
    tbl[2]  = mk(2, 0, 2, 2, 0, 0, 0, 0, 20, 3, 1, 1, 0, 0); // HAMBRIENTO
    tbl[3]  = mk(2, 0, 2, 2, 0, 0, 1, 0,  1, 6, 0, 0, 0, 0); // fed -> ATENDIDO
    tbl[4]  = mk(2, 2, 2, 2, 0, 0, 0, 0,  5, 6, 0, 0, 0, 0); // still holding
    tbl[5]  = mk(2, 2, 2, 2, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0); // hold over
    tbl[6]  = mk(2, 0, 2, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0); // Reset_General resync
    tbl[7]  = mk(2, 0, 2, 0, 0, 0, 0, 0, 20, 4, 0, 1, 0, 0); // ENFERMO beats hunger
    tbl[8]  = mk(2, 0, 2, 0, 0, 0, 1, 0,  1, 4, 0, 1, 0, 0); // wrong pulse ignored
    tbl[9]  = mk(2, 0, 2, 0, 0, 0, 0, 1,  1, 6, 0, 0, 0, 0); // medicine -> ATENDIDO
    tbl[10] = mk(2, 2, 2, 2, 0, 0, 0, 0,  6, 0, 1, 1, 0, 0);
    tbl[11] = mk(2, 2, 0, 2, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0);
    tbl[12] = mk(2, 2, 0, 2, 0, 0, 0, 0, 20, 5, 0, 0, 0, 0); // DORMIDO
    tbl[13] = mk(2, 2, 1, 2, 0, 0, 0, 0, 20, 5, 0, 0, 0, 0); // hysteresis
    tbl[14] = mk(2, 2, 2, 2, 0, 0, 0, 0, 20, 0, 1, 1, 0, 0); // wakes
    tbl[15] = mk(0, 3, 3, 3, 0, 0, 0, 0, 20, 2, 1, 1, 0, 0); // TRISTE, death count 1
    tbl[16] = mk(0, 3, 3, 3, 0, 0, 0, 0, 20, 2, 1, 1, 0, 0); // count 2
    tbl[17] = mk(0, 3, 3, 3, 0, 0, 0, 0, 20, 7, 0, 0, 1, 0); // count 3 -> MUERTO
    tbl[18] = mk(3, 3, 3, 3, 0, 0, 0, 0, 40, 7, 0, 0, 1, 0); // absorbing
    tbl[19] = mk(3, 3, 3, 3, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0); // revived
    tbl[20] = mk(3, 3, 3, 3, 0, 0, 0, 0, 20, 1, 1, 1, 0, 0);

    reset = 1'b0; Reset_General = 1'b0; Bot_Test_pulse = 1'b0;
    senal_5segEnergia = 1'b0; senal_5segMedicina = 1'b0;
    set_levels(3, 3, 3, 3);
    repeat (3) @(negedge clk);
    check("reset_state", 3'd0, 1, 1, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      run_vec(tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].est, tbl[i].ac, tbl[i].am, tbl[i].mu, tbl[i].mt);
    end

    // Test mode: evaluation every 4 cycles.
    set_levels(3, 0, 3, 3);
    Bot_Test_pulse = 1'b1; tick(1);
    check("test_on", 3'd1, 1, 1, 0, 1);
    tick(3);
    check("test_pre_eval", 3'd1, 1, 1, 0, 1);
    tick(1);
    check("test_eval", 3'd3, 1, 1, 0, 1);

    // Toggle on the eval cycle: no transition, prescaler restarts in normal mode.
    set_levels(3, 3, 3, 3);
    tick(3);
    Bot_Test_pulse = 1'b1; tick(1);
    check("coincident_toggle", 3'd3, 1, 1, 0, 0);
    tick(19);
    check("restart_pre", 3'd3, 1, 1, 0, 0);
    tick(1);
    check("restart_eval", 3'd1, 1, 1, 0, 0);

    // Reset_General outranks the toggle but keeps an existing test mode.
    Reset_General = 1'b1; Bot_Test_pulse = 1'b1; tick(1);
    check("rg_priority", 3'd0, 1, 1, 0, 0);
    Bot_Test_pulse = 1'b1; tick(1);
    Reset_General = 1'b1; tick(1);
    check("rg_keeps_test", 3'd0, 1, 1, 0, 1);

    // Async reset in the middle of ATENDIDO.
    set_levels(3, 0, 3, 3);
    tick(4);
    check("test_hungry", 3'd3, 1, 1, 0, 1);
    senal_5segEnergia = 1'b1; tick(1);
    check("test_fed", 3'd6, 0, 0, 0, 1);
    tick(2);
    reset = 1'b0;
    #1;
    check("async_reset", 3'd0, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
